// File: rtl/proc_demux_reg.sv
// proc_demux_reg
// Registered 1-to-4 demultiplexer with valid/ready handshakes on every port.
// A single producer presents one word per cycle together with a 2-bit select.
// The word is steered into a one-entry holding register owned by the selected
// destination (a..d). Each destination drains independently, so a stalled
// consumer only blocks words addressed to it.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_flush                   synchronous clear of all holding registers
//   i_demux_data/sel/valid    producer side; o_demux_ready is the accept
//   o_demux_data_x            held word for destination x (a..d)
//   o_demux_valid_x           destination x holding register full
//   i_demux_ready_x           destination x consumer accepts
//   o_busy                    any destination holding a word
module proc_demux_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int MUX_SEL_SZ = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_demux_data,
  input  logic [MUX_SEL_SZ-1:0] i_demux_sel,
  input  logic                  i_demux_valid,
  output logic                  o_demux_ready,
  output logic [DATA_WIDTH-1:0] o_demux_data_a,
  output logic [DATA_WIDTH-1:0] o_demux_data_b,
  output logic [DATA_WIDTH-1:0] o_demux_data_c,
  output logic [DATA_WIDTH-1:0] o_demux_data_d,
  output logic                  o_demux_valid_a,
  output logic                  o_demux_valid_b,
  output logic                  o_demux_valid_c,
  output logic                  o_demux_valid_d,
  input  logic                  i_demux_ready_a,
  input  logic                  i_demux_ready_b,
  input  logic                  i_demux_ready_c,
  input  logic                  i_demux_ready_d,
  output logic                  o_busy
);

  localparam int NDEST = 4;

  logic [NDEST-1:0]      consumer_ready;
  logic [NDEST-1:0]      full;
  logic [NDEST-1:0]      drain;
  logic [NDEST-1:0]      load;
  logic [NDEST-1:0]      full_nxt;
  logic [DATA_WIDTH-1:0] hold [NDEST];
  logic                  acc;

  assign consumer_ready = {i_demux_ready_d, i_demux_ready_c,
                           i_demux_ready_b, i_demux_ready_a};

  assign drain = full & consumer_ready;

  // Ready looks only at the selected destination; a draining destination can
  // take a new word in the same cycle, giving one word per cycle throughput.
  // i_demux_valid deliberately does not feed this path.
  assign o_demux_ready = ~i_flush & (~full[i_demux_sel] | drain[i_demux_sel]);

  assign acc = i_demux_valid & o_demux_ready;

  always_comb begin
    load = '0;
    if (acc) load[i_demux_sel] = 1'b1;
    // Drains on every port proceed even during a flush; the flush then
    // empties whatever is left.
    if (i_flush) full_nxt = '0;
    else         full_nxt = (full & ~drain) | load;
  end

  // Holding registers: data only moves on accept, so a held word is stable
  // for as long as its consumer withholds ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full <= '0;
      for (int i = 0; i < NDEST; i++) hold[i] <= '0;
    end else begin
      full <= full_nxt;
      for (int i = 0; i < NDEST; i++) begin
        if (load[i]) hold[i] <= i_demux_data;
      end
    end
  end

  assign o_demux_valid_a = full[0];
  assign o_demux_valid_b = full[1];
  assign o_demux_valid_c = full[2];
  assign o_demux_valid_d = full[3];
  assign o_demux_data_a  = hold[0];
  assign o_demux_data_b  = hold[1];
  assign o_demux_data_c  = hold[2];
  assign o_demux_data_d  = hold[3];
  assign o_busy          = |full;

endmodule

// File: tb/tb_proc_demux_reg.sv
// Testbench for proc_demux_reg. Stimulus pushes each accepted word into the
// queue of its destination; a separate monitor pops and compares whenever a
// destination completes a valid/ready handshake.
module tb_proc_demux_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        vin;
  logic        rdy_out;
  logic [31:0] data_a, data_b, data_c, data_d;
  logic        valid_a, valid_b, valid_c, valid_d;
  logic        ready_a, ready_b, ready_c, ready_d;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [4][$];

  proc_demux_reg #(.DATA_WIDTH(32), .MUX_SEL_SZ(2)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flush         (flush),
    .i_demux_data    (din),
    .i_demux_sel     (sel),
    .i_demux_valid   (vin),
    .o_demux_ready   (rdy_out),
    .o_demux_data_a  (data_a),
    .o_demux_data_b  (data_b),
    .o_demux_data_c  (data_c),
    .o_demux_data_d  (data_d),
    .o_demux_valid_a (valid_a),
    .o_demux_valid_b (valid_b),
    .o_demux_valid_c (valid_c),
    .o_demux_valid_d (valid_d),
    .i_demux_ready_a (ready_a),
    .i_demux_ready_b (ready_b),
    .i_demux_ready_c (ready_c),
    .i_demux_ready_d (ready_d),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a handshake is valid & ready as they stand before the next edge.
  always @(negedge clk) begin
    logic [3:0]  v;
    logic [3:0]  r;
    logic [31:0] d [4];
    v = {valid_d, valid_c, valid_b, valid_a};
    r = {ready_d, ready_c, ready_b, ready_a};
    d[0] = data_a; d[1] = data_b; d[2] = data_c; d[3] = data_d;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && r[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word dest %0d: got 0x%0h, required none", i, d[i]);
          end else begin
            chk($sformatf("drain_data_dest%0d", i), d[i], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one cycle; expects it to be accepted.
  task automatic send(input logic [1:0] s, input logic [31:0] w);
    sel = s; din = w; vin = 1'b1;
    #1;
    chk($sformatf("ready_send_sel%0d", s), {31'd0, rdy_out}, 32'd1);
    exp_q[s].push_back(w);
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; din = '0; sel = '0; vin = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0; ready_d = 1'b0;
    #12;
    // Reset state
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, rdy_out}, 32'd1);
    chk("reset_valids", {28'd0, valid_d, valid_c, valid_b, valid_a}, 32'd0);
    chk("reset_data_a", data_a, 32'd0);
    chk("reset_data_d", data_d, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single steer to c, then drain
    send(2'd2, 32'hDEADBEEF);
    chk("steer_valid_c", {31'd0, valid_c}, 32'd1);
    chk("steer_data_c", data_c, 32'hDEADBEEF);
    chk("steer_other_valids", {29'd0, valid_d, valid_b, valid_a}, 32'd0);
    chk("steer_busy", {31'd0, busy}, 32'd1);
    ready_c = 1'b1;
    step();
    ready_c = 1'b0;
    chk("steer_drained_c", {31'd0, valid_c}, 32'd0);

    // Backpressure isolation
    send(2'd0, 32'h1);
    sel = 2'd0; din = 32'h2; vin = 1'b1;
    #1;
    chk("bp_ready_sel0", {31'd0, rdy_out}, 32'd0);
    step();
    vin = 1'b0;
    chk("bp_data_a_held", data_a, 32'h1);
    sel = 2'd1; din = 32'h3; vin = 1'b1;
    #1;
    chk("bp_ready_sel1", {31'd0, rdy_out}, 32'd1);
    exp_q[1].push_back(32'h3);
    step();
    vin = 1'b0;
    chk("bp_data_b", data_b, 32'h3);
    chk("bp_data_a_still", data_a, 32'h1);
    chk("bp_valid_a", {31'd0, valid_a}, 32'd1);
    ready_a = 1'b1; ready_b = 1'b1;
    step();
    ready_a = 1'b0; ready_b = 1'b0;
    chk("bp_drained", {30'd0, valid_b, valid_a}, 32'd0);

    // Back-to-back to d with consumer ready
    ready_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = 2'd3; din = 32'h10 + k; vin = 1'b1;
      #1;
      chk($sformatf("b2b_ready_%0d", k), {31'd0, rdy_out}, 32'd1);
      exp_q[3].push_back(32'h10 + k);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_valid_d_%0d", k), {31'd0, valid_d}, 32'd1);
      chk($sformatf("b2b_data_d_%0d", k), data_d, 32'h10 + k);
    end
    vin = 1'b0;
    step();
    chk("b2b_drained_d", {31'd0, valid_d}, 32'd0);
    ready_d = 1'b0;

    // Flush with a, b, c full
    send(2'd0, 32'hA1);
    send(2'd1, 32'hB2);
    send(2'd2, 32'hC3);
    sel = 2'd0; din = 32'h55; vin = 1'b1; flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, rdy_out}, 32'd0);
    step();
    flush = 1'b0; vin = 1'b0;
    chk("flush_valids", {28'd0, valid_d, valid_c, valid_b, valid_a}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_data_a", data_a, 32'hA1);
    clear_queues();

    // Parallel drain while accepting to b
    send(2'd0, 32'h100);
    send(2'd1, 32'h101);
    send(2'd2, 32'h102);
    send(2'd3, 32'h103);
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1; ready_d = 1'b1;
    sel = 2'd1; din = 32'h200; vin = 1'b1;
    #1;
    chk("par_ready", {31'd0, rdy_out}, 32'd1);
    exp_q[1].push_back(32'h200);
    step();
    vin = 1'b0;
    ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0; ready_d = 1'b0;
    chk("par_valids", {28'd0, valid_d, valid_c, valid_b, valid_a}, 32'h2);
    chk("par_data_b", data_b, 32'h200);
    ready_b = 1'b1;
    step();
    ready_b = 1'b0;
    chk("par_drained_b", {31'd0, valid_b}, 32'd0);

    // Asynchronous reset mid-cycle with b full
    send(2'd1, 32'h77);
    chk("rst_pre_valid_b", {31'd0, valid_b}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid_b", {31'd0, valid_b}, 32'd0);
    chk("rst_data_all", data_a | data_b | data_c | data_d, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, rdy_out}, 32'd1);
    clear_queues();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_empty_dest%0d", i), exp_q[i].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_demux_reg.md
# proc_demux_reg

Registered 1-to-4 demultiplexer with a valid/ready handshake on every port, the write-side counterpart of the processor datapath select mux. It accepts one data word per cycle from a single producer, such as the execute/writeback result path, and steers it to one of four consumer ports chosen by `i_demux_sel`. Each destination has its own one-entry holding register, so a stalled consumer blocks only traffic addressed to it.

## Interface
- `DATA_WIDTH`, 32: width of data words.
- `MUX_SEL_SZ`, 2: select width; fixed at 2 (four destinations a..d); other values unsupported.
- `i_clk` in 1: single clock; all state updates on rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_flush` in 1: synchronous clear of all holding registers.
- `i_demux_data` in DATA_WIDTH: input word.
- `i_demux_sel` in MUX_SEL_SZ: destination; 0=a, 1=b, 2=c, 3=d.
- `i_demux_valid` in 1: input word and select valid.
- `o_demux_ready` out 1: block accepts input this cycle.
- `o_demux_data_a`..`o_demux_data_d` out DATA_WIDTH each: held word per destination.
- `o_demux_valid_a`..`o_demux_valid_d` out 1 each: destination holding register full.
- `i_demux_ready_a`..`i_demux_ready_d` in 1 each: destination consumer accepts.
- `o_busy` out 1: OR of all four `o_demux_valid_*`.

## Operation
- Per destination x: one holding register `data_x` and one full flag `full_x`. `o_demux_valid_x = full_x` and `o_demux_data_x = data_x`, both driven directly from flops.
- Drain: `drain_x = full_x & i_demux_ready_x`.
- Input ready, combinational: `o_demux_ready = ~i_flush & (~full[sel] | drain[sel])`, where `sel = i_demux_sel`. It depends only on the selected destination.
- Accept: `acc = i_demux_valid & o_demux_ready`. On accept, `data[sel] <= i_demux_data` and `full[sel] <= 1`.
- Destination not selected or not accepted:
  - `full_x` clears if `drain_x`.
  - `data_x` holds its value.
- Simultaneous drain and accept on the same destination: `full_x` stays 1 and `data_x` takes the new word. This allows one word per cycle of throughput per destination.
- Different destinations drain independently in the same cycle; drains on non-selected ports always proceed.
- Flush, when `i_flush=1`:
  - all `full_x` go to 0 at the edge;
  - no accept that cycle (`o_demux_ready=0`);
  - `data_x` is unchanged;
  - a consumer handshake during a flush cycle still counts as a completed transfer for that consumer.
- `i_demux_valid=0`: `o_demux_ready` is still computed and may be 1; no state changes except drains.
- Input rule: the producer must hold data and select stable while valid is asserted and ready is low.
- Output rule: `data_x` never changes while `full_x=1` and `i_demux_ready_x=0`.

## Timing
- Reset, asynchronous on `i_rst_n` low: all `full_x` = 0, all `data_x` = 0, `o_busy` = 0.
- While `i_rst_n` is low, `o_demux_ready` = 1 unless `i_flush` is high. It is combinational from the cleared flags.
- Release of `i_rst_n` is synchronous to `i_clk` at the system level. A reset asserted mid-transfer discards all held words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N appears on `o_demux_valid_x`/`o_demux_data_x` after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle aggregate. Sustained one per cycle to a single destination requires its consumer to hold ready high.
- Full destination with consumer not ready: `o_demux_ready` = 0 only while `i_demux_sel` points at it. The producer may not retarget a pending word.
- Combinational paths: `i_demux_sel`, `i_demux_ready_*`, `i_flush` → `o_demux_ready`. There is no path from `i_demux_valid` to `o_demux_ready`.

## Test plan
- Reset/idle:
  - Stimulus: assert `i_rst_n=0` mid-cycle with `full_b=1`.
  - Required: `o_demux_valid_b` drops immediately; all data = 0; `o_busy=0`; `o_demux_ready=1`.
- Single steer:
  - Stimulus: sel=2, data=0xDEADBEEF, valid for one cycle.
  - Required: next cycle `o_demux_valid_c=1`, `o_demux_data_c=0xDEADBEEF`, other valids 0.
  - Then: `i_demux_ready_c=1` → `valid_c=0` the following cycle.
- Backpressure isolation:
  - Stimulus: fill a (0x1) with `i_demux_ready_a=0`, then present sel=0 data 0x2 and sel=1 data 0x3.
  - Required: ready=0 for sel=0; ready=1 for sel=1; `data_b=0x3` accepted; `data_a` stays 0x1.
- Back-to-back same destination:
  - Stimulus: `i_demux_ready_d=1`; stream 0x10, 0x11, 0x12 to sel=3 on consecutive cycles.
  - Required: ready stays 1; `data_d` shows 0x10, 0x11, 0x12 on consecutive cycles; `valid_d` high for three cycles.
- Flush:
  - Stimulus: a, b, c full, consumers not ready; assert `i_flush` together with valid sel=0.
  - Required: `o_demux_ready=0`; next cycle all valids 0; `data_a` unchanged.
- Parallel drain:
  - Stimulus: all four full with distinct values; raise all consumer readies in one cycle while accepting to sel=1.
  - Required: next cycle only `valid_b=1` with the new word; a, c, d cleared.
